// File: rtl/decade_count_ctrl.sv
// Cascaded BCD counter with IDLE/RUN/PAUSE/DONE control, terminal-value detect and wrap pulse.
// Define DECADE_COUNT_CTRL_DOWN_EN to build the borrow chain and honour up_dn; otherwise up-only.
module decade_count_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic                  tick,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]    r_state;
  logic [W-1:0]  r_count;
  logic          r_done;
  logic          r_wrap;
  logic          r_err;

  logic [1:0]    w_state_next;
  logic [W-1:0]  w_count_next;
  logic          w_done_next;
  logic          w_wrap_next;
  logic          w_err_set;

  logic [W-1:0]      w_inc;
  logic [DIGITS:0]   w_carry;
  logic [W-1:0]      w_load_clean;
  logic [DIGITS-1:0] w_load_bad;
  logic [W-1:0]      w_step;
  logic              w_step_wrap;
  logic              w_hit;

`ifdef DECADE_COUNT_CTRL_DOWN_EN
  logic [W-1:0]      w_dec;
  logic [DIGITS:0]   w_borrow;
  assign w_borrow[0] = 1'b1;
`endif

  assign w_carry[0] = 1'b1;

  // Per-digit step logic: a digit moves only when every lower digit is at its rollover value.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_ld;
    assign w_dig = r_count[4*gi +: 4];
    assign w_ld  = load_val[4*gi +: 4];
    assign w_load_bad[gi]          = (w_ld > 4'd9);
    assign w_load_clean[4*gi +: 4] = w_load_bad[gi] ? 4'd9 : w_ld;
    assign w_inc[4*gi +: 4]        = !w_carry[gi] ? w_dig :
                                     (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
    assign w_carry[gi+1]           = w_carry[gi] & (w_dig == 4'd9);
`ifdef DECADE_COUNT_CTRL_DOWN_EN
    assign w_dec[4*gi +: 4]        = !w_borrow[gi] ? w_dig :
                                     (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
    assign w_borrow[gi+1]          = w_borrow[gi] & (w_dig == 4'd0);
`endif
  end

`ifdef DECADE_COUNT_CTRL_DOWN_EN
  assign w_step      = up_dn ? w_inc : w_dec;
  assign w_step_wrap = up_dn ? w_carry[DIGITS] : w_borrow[DIGITS];
`else
  logic w_unused_up_dn;
  assign w_unused_up_dn = up_dn;
  assign w_step      = w_inc;
  assign w_step_wrap = w_carry[DIGITS];
`endif

  // Terminal detect looks at the post-step value, so a run started at limit needs a full cycle.
  assign w_hit = (w_step == limit);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
      r_wrap  <= w_wrap_next;
      r_err   <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!load && !stop && start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (stop)               w_state_next = S_PAUSE;
        else if (tick && w_hit) w_state_next = S_DONE;
      end
      S_PAUSE: begin
        if (load)       w_state_next = S_PAUSE;
        else if (stop)  w_state_next = S_IDLE;
        else if (start) w_state_next = S_RUN;
      end
      default: begin
        if (load || stop) w_state_next = S_IDLE;
        else if (start)   w_state_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    w_done_next  = 1'b0;
    w_wrap_next  = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE, S_PAUSE: begin
        if (load) begin
          w_count_next = w_load_clean;
          w_err_set    = |w_load_bad;
        end
      end
      S_RUN: begin
        if (!stop && tick) begin
          w_count_next = w_step;
          w_wrap_next  = w_step_wrap;
          w_done_next  = w_hit;
        end
      end
      default: begin
        if (load) begin
          w_count_next = w_load_clean;
          w_err_set    = |w_load_bad;
        end else if (!stop && start) begin
          w_count_next = '0;
        end
      end
    endcase
  end

  assign count = r_count;
  assign state = r_state;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_decade_count_ctrl.sv
// Bench for decade_count_ctrl: integer-valued reference model, per-cycle compare, directed and random phases.
module tb_decade_count_ctrl;

  localparam int D = 4;
  localparam int M = 10000;

  logic        clk = 1'b0;
  logic        clr = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, tick = 1'b0, up_dn = 1'b1;
  logic [15:0] load_val = '0, limit = '0;
  logic [15:0] count;
  logic [1:0]  state;
  logic        busy, done, wrap, err;

  decade_count_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .tick(tick), .up_dn(up_dn),
    .count(count), .state(state), .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // Reference model: count held as a plain integer 0..M-1
  int m_cnt = 0, m_state = 0, m_done = 0, m_wrap = 0, m_err = 0;

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      v = v + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_load();
    int v, p, dg;
    v = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      dg = int'(load_val[4*i +: 4]);
      if (dg > 9) begin
        dg = 9;
        m_err = 1;
      end
      v = v + dg * p;
      p = p * 10;
    end
    m_cnt = v;
  endtask

  task automatic model_step();
    int nxt;
    bit down;
`ifdef DECADE_COUNT_CTRL_DOWN_EN
    down = !up_dn;
`else
    down = 0;
`endif
    if (down) begin
      m_wrap = (m_cnt == 0);
      nxt = (m_cnt + M - 1) % M;
    end else begin
      m_wrap = (m_cnt == M - 1);
      nxt = (m_cnt + 1) % M;
    end
    m_cnt = nxt;
    if (nxt == bcd2int(limit)) begin
      m_done = 1;
      m_state = 3;
    end
  endtask

  task automatic model_update();
    m_done = 0;
    m_wrap = 0;
    if (clr) begin
      m_cnt = 0; m_state = 0; m_err = 0;
    end else begin
      case (m_state)
        0: if (load) model_load(); else if (!stop && start) m_state = 1;
        1: if (stop) m_state = 2; else if (tick) model_step();
        2: if (load) model_load(); else if (stop) m_state = 0; else if (start) m_state = 1;
        default: begin
          if (load) begin model_load(); m_state = 0; end
          else if (stop) m_state = 0;
          else if (start) begin m_cnt = 0; m_state = 1; end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Single compare process: DUT outputs against the model, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("count", 32'(count), 32'(int2bcd(m_cnt)));
      chk("state", 32'(state), 32'(m_state));
      chk("busy",  32'(busy),  32'(m_state == 1));
      chk("done",  32'(done),  32'(m_done));
      chk("wrap",  32'(wrap),  32'(m_wrap));
      chk("err",   32'(err),   32'(m_err));
    end
  end

  task automatic drive(input bit c_clr, input bit c_load, input bit c_stop, input bit c_start, input bit c_tick);
    clr = c_clr; load = c_load; stop = c_stop; start = c_start; tick = c_tick;
    @(posedge clk);
    model_update();
    @(negedge clk);
    clr = 0; load = 0; stop = 0; start = 0; tick = 0;
  endtask

  task automatic lit(input string name, input logic [15:0] c, input logic [1:0] s, input bit d, input bit w);
    $display("txn %s: count=%h state=%0d done=%0b wrap=%0b err=%0b", name, count, state, done, wrap, err);
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_state"}, 32'(state), 32'(s));
    chk({name, "_done"},  32'(done),  32'(d));
    chk({name, "_wrap"},  32'(wrap),  32'(w));
  endtask

  function automatic int pick_near(input int base);
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 4));
      1: return int'($urandom_range(M - 5, M - 1));
      2: return int'($urandom_range(0, M - 1));
      default: return (base + M + int'($urandom_range(0, 12)) - 6) % M;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    // Reset and first run through 0995 -> 1002
    drive(1, 1, 0, 1, 1);
    chk_en = 1;
    lit("reset", 16'h0000, 2'd0, 0, 0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    load_val = 16'h0995; limit = 16'h1002;
    drive(0, 1, 0, 0, 0);
    lit("load0995", 16'h0995, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 0);
    lit("start", 16'h0995, 2'd1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      drive(0, 0, 0, 0, 1);
      lit("run", int2bcd(995 + i), (i == 7) ? 2'd3 : 2'd1, i == 7, 0);
    end
    chk("done_busy", 32'(busy), 32'd0);
    drive(0, 0, 0, 0, 1);
    lit("done_hold", 16'h1002, 2'd3, 0, 0);

    // Wrap then terminal
    load_val = 16'h9998; limit = 16'h0001;
    drive(0, 1, 0, 0, 0);
    lit("done_load", 16'h9998, 2'd0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    lit("w9999", 16'h9999, 2'd1, 0, 0);
    drive(0, 0, 0, 0, 1);
    lit("w0000", 16'h0000, 2'd1, 0, 1);
    drive(0, 0, 0, 0, 1);
    lit("w0001", 16'h0001, 2'd3, 1, 0);

    // Pause / resume / idle
    load_val = 16'h0039; limit = 16'h9000;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    lit("p0040", 16'h0040, 2'd1, 0, 0);
    drive(0, 0, 1, 0, 1);
    lit("pause", 16'h0040, 2'd2, 0, 0);
    drive(0, 0, 0, 1, 1);
    lit("resume", 16'h0040, 2'd1, 0, 0);
    drive(0, 0, 0, 0, 1);
    lit("p0041", 16'h0041, 2'd1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    lit("idle", 16'h0041, 2'd0, 0, 0);

    // Invalid digit load, sticky err
    load_val = 16'h00A3;
    drive(0, 1, 0, 0, 0);
    lit("bad_load", 16'h0093, 2'd0, 0, 0);
    chk("err_set", 32'(err), 32'd1);
    load_val = 16'h0499;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("err_sticky", 32'(err), 32'd1);
    lit("r0500", 16'h0500, 2'd1, 0, 0);
    drive(1, 1, 0, 1, 1);
    lit("clr_run", 16'h0000, 2'd0, 0, 0);
    chk("err_clr", 32'(err), 32'd0);

    // Start at limit: no done until a full modulus cycle
    load_val = 16'h0005; limit = 16'h0005;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    lit("at_limit", 16'h0006, 2'd1, 0, 0);

    // Direction
    drive(1, 0, 0, 0, 0);
    load_val = 16'h0001; limit = 16'h9998; up_dn = 0;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
`ifdef DECADE_COUNT_CTRL_DOWN_EN
    drive(0, 0, 0, 0, 1);
    lit("d0000", 16'h0000, 2'd1, 0, 0);
    drive(0, 0, 0, 0, 1);
    lit("d9999", 16'h9999, 2'd1, 0, 1);
    drive(0, 0, 0, 0, 1);
    lit("d9998", 16'h9998, 2'd3, 1, 0);
`else
    drive(0, 0, 0, 0, 1);
    lit("u0002", 16'h0002, 2'd1, 0, 0);
    drive(0, 0, 0, 0, 1);
    lit("u0003", 16'h0003, 2'd1, 0, 0);
`endif
    up_dn = 1;

    // Randomized phase, checked by the compare process every cycle
    for (int n = 0; n < 4000; n++) begin
      bit r_clr, r_load, r_stop, r_start, r_tick;
      r_clr   = ($urandom_range(0, 99) < 2);
      r_load  = ($urandom_range(0, 9) == 0);
      r_stop  = ($urandom_range(0, 11) == 0);
      r_start = ($urandom_range(0, 4) == 0);
      r_tick  = ($urandom_range(0, 3) != 0);
      up_dn   = 1'($urandom_range(0, 1));
      load_val = int2bcd(pick_near(m_cnt));
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = int'($urandom_range(0, D - 1));
        load_val[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      if ($urandom_range(0, 19) == 0) limit = int2bcd(pick_near(m_cnt));
      drive(r_clr, r_load, r_stop, r_start, r_tick);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decade_count_ctrl.md
DECADE_COUNT_CTRL -- requirements
Module: decade_count_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of cascaded BCD (mod-10) digits (range 1-8).
REQ-002 clk  in  1  Single clock; all state changes on the rising edge.
REQ-003 clr  in  1  Reset, synchronous, active-high.
REQ-004 start  in  1  Level command: begin or resume counting.
REQ-005 stop  in  1  Level command: pause, or return to idle from pause.
REQ-006 load  in  1  Level command: preset the count from load_val.
REQ-007 load_val  in  4*DIGITS  BCD preset, digit 0 in bits [3:0].
REQ-008 limit  in  4*DIGITS  BCD terminal value.
REQ-009 tick  in  1  Count-enable qualifier; one count per clock with tick=1 in RUN.
REQ-010 up_dn  in  1  Direction: 1 = up, 0 = down (see REQ-031).
REQ-011 count  out  4*DIGITS  Current BCD count, registered.
REQ-012 state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-013 busy  out  1  High only in RUN.
REQ-014 done  out  1  One-cycle pulse when RUN -> DONE.
REQ-015 wrap  out  1  One-cycle pulse when the count wraps (all-9 -> all-0 up; all-0 -> all-9 down).
REQ-016 err  out  1  Sticky; set when a load contains a digit > 9.

Function
REQ-017 Command priority SHALL be clr > load > stop > start > tick.
REQ-018 In IDLE: load -> count <= load_val next edge, stay IDLE; start -> RUN; no counting.
REQ-019 In RUN: each edge with tick=1 SHALL step count by one, digit i carries/borrows into digit i+1 only when digits 0..i are all 9 (up) or all 0 (down).
REQ-020 In RUN: when the next count equals limit, count SHALL be updated, state SHALL become DONE and done SHALL pulse for exactly that cycle.
REQ-021 In RUN: stop -> PAUSE, count held, no step on that edge even if tick=1; load is ignored in RUN.
REQ-022 In PAUSE: start -> RUN; stop -> IDLE; load -> count <= load_val, stay PAUSE.
REQ-023 In DONE: count held; start -> count <= 0, state RUN; load -> count <= load_val, state IDLE; stop -> IDLE.
REQ-024 Starting with count == limit SHALL not signal done until the count has stepped away and returned to limit (full modulus cycle).
REQ-025 Full-range wrap SHALL be modulo 10^DIGITS, pulse wrap in the wrap cycle, and not change state unless REQ-020 also applies (both pulses may coincide).
REQ-026 Any loaded digit > 9 SHALL be stored as 9 and SHALL set err; err clears only on clr.
REQ-027 Latency: count, state, done, wrap SHALL all reflect a command or tick on the first edge after it is sampled; no combinational path from inputs to outputs.

Reset
REQ-028 With clr=1 at an edge: state=IDLE, count=0, busy=0, done=0, wrap=0, err=0; clr dominates all commands.
REQ-029 clr asserted mid-RUN SHALL abandon the run with no done or wrap pulse.

Configuration
REQ-030 Macro DECADE_COUNT_CTRL_DOWN_EN SHALL control down-counting support.
REQ-031 Defined: up_dn honoured per REQ-019/025. Undefined: up_dn ignored, block counts up only, no borrow logic built.

Verification
REQ-032 DIGITS=4, clr, load 0995, limit 1002, start, tick=1 -> counts 0996..1002, done pulses on the 1002 cycle, state=DONE, busy=0.
REQ-033 load 9998, limit 0001, start, tick=1 -> 9999, 0000 (wrap pulse), 0001 (done pulse).
REQ-034 RUN at 0040, stop with tick=1 -> PAUSE, count stays 0040; start -> resumes 0041; stop twice -> IDLE.
REQ-035 load_val 0x00A3 in IDLE -> count 0093, err=1 and stays 1 until clr.
REQ-036 With DECADE_COUNT_CTRL_DOWN_EN, up_dn=0, load 0001, limit 9998, start -> 0000, 9999 (wrap), 9998 (done); without the macro same stimulus counts 0002 upward.
REQ-037 clr asserted at count 0500 in RUN together with start and load -> next cycle state=IDLE, count=0000, no done/wrap pulse.
